// File: rtl/motion_update_velocity_broadcaster.sv
// Sweeps every cell, reads its particle count then each velocity/force pair,
// and broadcasts v + (f >>> DT_SHIFT) tagged with the destination cell.
module motion_update_velocity_broadcaster #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned PARTICLE_NUM  = 220,
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned CELL_ID_WIDTH = 4,
  parameter int unsigned X_DIM         = 3,
  parameter int unsigned Y_DIM         = 4,
  parameter int unsigned Z_DIM         = 3,
  parameter int unsigned DT_SHIFT      = 8,
  parameter int unsigned READ_LATENCY  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic [3*CELL_ID_WIDTH-1:0]   out_rd_cell,
  output logic [ADDR_WIDTH-1:0]        out_rd_address,
  output logic                         out_rden,
  input  logic [3*DATA_WIDTH-1:0]      in_velocity,
  input  logic [3*DATA_WIDTH-1:0]      in_force,
  input  logic [3*CELL_ID_WIDTH-1:0]   in_dst_cell,
  output logic                         motion_update_enable,
  output logic [3*DATA_WIDTH-1:0]      out_data,
  output logic [3*CELL_ID_WIDTH-1:0]   out_data_dst_cell,
  output logic                         out_data_valid,
  output logic                         out_done
);

  localparam int unsigned CW     = CELL_ID_WIDTH;
  localparam int unsigned DW     = DATA_WIDTH;
  localparam int unsigned AW     = ADDR_WIDTH;
  localparam int unsigned RL     = READ_LATENCY;
  localparam int unsigned WAIT_W = $clog2(READ_LATENCY + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RD_NUM    = 3'd1;
  localparam logic [2:0] S_WAIT_NUM  = 3'd2;
  localparam logic [2:0] S_STREAM    = 3'd3;
  localparam logic [2:0] S_DRAIN     = 3'd4;
  localparam logic [2:0] S_NEXT_CELL = 3'd5;
  localparam logic [2:0] S_FINISH    = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     x_q, x_d, y_q, y_d, z_q, z_d;
  logic [AW-1:0]     count_q, count_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              rden_q, rden_d;
  logic [3*CW-1:0]   rd_cell_q, rd_cell_d;
  logic              enable_q, enable_d;
  logic              done_q, done_d;
  logic [RL-1:0]     tag_q, tag_d;
  logic [3*DW-1:0]   data_q, data_d;
  logic [3*CW-1:0]   dst_q, dst_d;
  logic              valid_q, valid_d;

  // Sweep control; outputs are registered from the next-state decision so they align with the state.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    count_d = count_q;
    wait_d  = wait_q;
    addr_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RD_NUM;
      end
      S_RD_NUM: begin
        wait_d  = '0;
        state_d = S_WAIT_NUM;
      end
      S_WAIT_NUM: begin
        if (wait_q == WAIT_W'(RL - 1)) begin
          count_d = (in_velocity[AW-1:0] > AW'(PARTICLE_NUM)) ? AW'(PARTICLE_NUM)
                                                              : in_velocity[AW-1:0];
          if (count_d == '0) begin
            state_d = S_NEXT_CELL;
          end else begin
            state_d = S_STREAM;
            addr_d  = AW'(1);
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_STREAM: begin
        if (addr_q == count_q) begin
          wait_d  = '0;
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      S_DRAIN: begin
        if (wait_q == WAIT_W'(RL - 1)) state_d = S_NEXT_CELL;
        else                           wait_d  = wait_q + WAIT_W'(1);
      end
      S_NEXT_CELL: begin
        state_d = S_RD_NUM;
        if (z_q != CW'(Z_DIM)) begin
          z_d = z_q + CW'(1);
        end else begin
          z_d = CW'(1);
          if (y_q != CW'(Y_DIM)) begin
            y_d = y_q + CW'(1);
          end else begin
            y_d = CW'(1);
            if (x_q != CW'(X_DIM)) begin
              x_d = x_q + CW'(1);
            end else begin
              x_d     = CW'(1);
              state_d = S_FINISH;
            end
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    rden_d    = (state_d == S_RD_NUM) || (state_d == S_STREAM);
    rd_cell_d = rden_d ? {x_d, y_d, z_d} : '0;
    enable_d  = (state_d != S_IDLE) && (state_d != S_FINISH);
    done_d    = (state_d == S_FINISH);
  end

  // Tag pipeline tracks which returning words are particle data, then the velocity update.
  always_comb begin
    logic signed [DW-1:0] v_c;
    logic signed [DW-1:0] f_c;
    v_c     = '0;
    f_c     = '0;
    tag_d   = RL'({tag_q, (rden_q && (addr_q != '0))});
    valid_d = tag_q[RL-1];
    data_d  = '0;
    dst_d   = '0;
    if (tag_q[RL-1]) begin
      for (int i = 0; i < 3; i++) begin
        v_c = in_velocity[i*DW +: DW];
        f_c = in_force[i*DW +: DW];
        data_d[i*DW +: DW] = v_c + (f_c >>> DT_SHIFT);
      end
      dst_d = in_dst_cell;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      x_q       <= CW'(1);
      y_q       <= CW'(1);
      z_q       <= CW'(1);
      count_q   <= '0;
      addr_q    <= '0;
      wait_q    <= '0;
      rden_q    <= 1'b0;
      rd_cell_q <= '0;
      enable_q  <= 1'b0;
      done_q    <= 1'b0;
      tag_q     <= '0;
      data_q    <= '0;
      dst_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      wait_q    <= wait_d;
      rden_q    <= rden_d;
      rd_cell_q <= rd_cell_d;
      enable_q  <= enable_d;
      done_q    <= done_d;
      tag_q     <= tag_d;
      data_q    <= data_d;
      dst_q     <= dst_d;
      valid_q   <= valid_d;
    end
  end

  assign out_rd_cell          = rd_cell_q;
  assign out_rd_address       = addr_q;
  assign out_rden             = rden_q;
  assign motion_update_enable = enable_q;
  assign out_data             = data_q;
  assign out_data_dst_cell    = dst_q;
  assign out_data_valid       = valid_q;
  assign out_done             = done_q;

endmodule

// File: tb/tb_motion_update_velocity_broadcaster.sv
// Bench for motion_update_velocity_broadcaster: cell memory model with two-cycle
// read latency, plus a scoreboard of expected velocity updates.
module tb_motion_update_velocity_broadcaster;

  localparam int RL    = 2;
  localparam int PN    = 220;
  localparam int NCELL = 36;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] out_rd_cell;
  logic [7:0]  out_rd_address;
  logic        out_rden;
  logic [95:0] in_velocity;
  logic [95:0] in_force;
  logic [11:0] in_dst_cell;
  logic        motion_update_enable;
  logic [95:0] out_data;
  logic [11:0] out_data_dst_cell;
  logic        out_data_valid;
  logic        out_done;

  motion_update_velocity_broadcaster dut (
    .clk(clk), .rst(rst), .start(start),
    .out_rd_cell(out_rd_cell), .out_rd_address(out_rd_address), .out_rden(out_rden),
    .in_velocity(in_velocity), .in_force(in_force), .in_dst_cell(in_dst_cell),
    .motion_update_enable(motion_update_enable), .out_data(out_data),
    .out_data_dst_cell(out_data_dst_cell), .out_data_valid(out_data_valid),
    .out_done(out_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cnts [NCELL];
  int mode = 0;

  logic [95:0] q_data [$];
  logic [11:0] q_dst  [$];
  int          beats, reads, done_cnt;
  logic [95:0] last_beat;
  int          ex, ey, ez, exp_addr;

  function automatic int cidx(logic [11:0] c);
    int x, y, z;
    x = int'(c[11:8]); y = int'(c[7:4]); z = int'(c[3:0]);
    if (x < 1 || x > 3 || y < 1 || y > 4 || z < 1 || z > 3) return -1;
    return (x - 1) * 12 + (y - 1) * 3 + (z - 1);
  endfunction

  function automatic logic [31:0] hsh(logic [11:0] c, logic [7:0] a, int k);
    return ({20'd0, c} * 32'd2654435761) ^ ({24'd0, a} << (k * 3)) ^ (32'(k) * 32'h01234567);
  endfunction

  function automatic logic [95:0] vel_of(logic [11:0] c, logic [7:0] a);
    int i;
    logic [87:0] junk;
    junk = 88'hA5A5A5A5A5A5A5A5A5A5A5;
    if (a == 8'd0) begin
      i = cidx(c);
      return {junk, (i < 0) ? 8'd0 : 8'(cnts[i])};
    end
    if (mode == 0) return {32'd30, 32'd20, 32'd10};
    if (mode == 2) return {32'd0, 32'd0, 32'h7FFFFFFF};
    return {hsh(c, a, 1), hsh(c, a, 2), hsh(c, a, 3)};
  endfunction

  function automatic logic [95:0] frc_of(logic [11:0] c, logic [7:0] a);
    if (mode == 0) return {32'hFFFFFF00, 32'd512, 32'd256};
    if (mode == 2) return {32'd0, 32'd0, 32'h00000100};
    return {hsh(c, a, 4), hsh(c, a, 5), hsh(c, a, 6)};
  endfunction

  function automatic logic [11:0] dst_of(logic [11:0] c, logic [7:0] a);
    return c ^ {a[3:0], a[7:4], 4'hC};
  endfunction

  // v + floor(f / 256), wrapped to 32 bits
  function automatic logic [31:0] upd(logic [31:0] v, logic [31:0] f);
    longint fv, q;
    fv = longint'($signed(f));
    q  = fv / 256;
    if (fv < 0 && (fv % 256) != 0) q = q - 1;
    return 32'(longint'($signed(v)) + q);
  endfunction

  function automatic int sweep_len();
    int s, n;
    s = 2;
    for (int i = 0; i < NCELL; i++) begin
      n = (cnts[i] > PN) ? PN : cnts[i];
      s += (n == 0) ? (2 + RL) : (2 + 2 * RL + n);
    end
    return s;
  endfunction

  function automatic int total_beats();
    int s;
    s = 0;
    for (int i = 0; i < NCELL; i++) s += (cnts[i] > PN) ? PN : cnts[i];
    return s;
  endfunction

  // Cell memory model: data appears RL cycles after the address.
  logic [11:0] p_cell;
  logic [7:0]  p_addr;
  always @(posedge clk) begin
    p_cell      <= out_rd_cell;
    p_addr      <= out_rd_address;
    in_velocity <= vel_of(p_cell, p_addr);
    in_force    <= frc_of(p_cell, p_addr);
    in_dst_cell <= dst_of(p_cell, p_addr);
  end

  // Scoreboard: push on each particle read, pop on each valid beat.
  always @(negedge clk) begin
    logic [95:0] v, f, e;
    logic [11:0] ed;
    if (!rst) begin
      if (out_rden && out_rd_address == 8'd0) begin
        n_tests++;
        if (out_rd_cell !== {4'(ex), 4'(ey), 4'(ez)}) begin
          n_fail++;
          $display("FAIL cell_order: got %h want %h", out_rd_cell, {4'(ex), 4'(ey), 4'(ez)});
        end
        if (ez < 3) ez++;
        else begin
          ez = 1;
          if (ey < 4) ey++;
          else begin ey = 1; ex = (ex < 3) ? ex + 1 : 1; end
        end
        exp_addr = 1;
      end else if (out_rden) begin
        n_tests++;
        if (int'(out_rd_address) != exp_addr) begin
          n_fail++;
          $display("FAIL rd_address: got %0d want %0d", out_rd_address, exp_addr);
        end
        exp_addr++;
        reads++;
        v = vel_of(out_rd_cell, out_rd_address);
        f = frc_of(out_rd_cell, out_rd_address);
        e = {upd(v[95:64], f[95:64]), upd(v[63:32], f[63:32]), upd(v[31:0], f[31:0])};
        if (mode == 0) e = {32'd29, 32'd22, 32'd11};
        ed = dst_of(out_rd_cell, out_rd_address);
        q_data.push_back(e);
        q_dst.push_back(ed);
      end else if (out_rd_address != 8'd0) begin
        n_tests++; n_fail++;
        $display("FAIL idle_address: got %0d want 0", out_rd_address);
      end
      if (out_data_valid) begin
        beats++;
        last_beat = out_data;
        n_tests++;
        if (motion_update_enable !== 1'b1) begin
          n_fail++;
          $display("FAIL valid_without_enable: enable %b want 1", motion_update_enable);
        end
        n_tests++;
        if (q_data.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got %h want none", out_data);
        end else begin
          e  = q_data.pop_front();
          ed = q_dst.pop_front();
          if (out_data !== e || out_data_dst_cell !== ed) begin
            n_fail++;
            $display("FAIL beat_data: got %h/%h want %h/%h", out_data, out_data_dst_cell, e, ed);
          end
        end
      end else if (out_data !== 96'd0 || out_data_dst_cell !== 12'd0) begin
        n_tests++; n_fail++;
        $display("FAIL idle_data: got %h/%h want 0/0", out_data, out_data_dst_cell);
      end
      if (out_done) done_cnt++;
    end
  end

  task automatic clear_sb();
    q_data.delete();
    q_dst.delete();
    ex = 1; ey = 1; ez = 1; exp_addr = 1;
  endtask

  task automatic set_counts(input int kind);
    for (int i = 0; i < NCELL; i++) cnts[i] = (kind == 1) ? int'($urandom_range(0, 4)) : 0;
  endtask

  task automatic run_sweep(input int extra_at, output int cyc);
    beats = 0; reads = 0; done_cnt = 0;
    @(posedge clk); #1 start = 1'b1; cyc = 1;
    @(posedge clk); #1 start = 1'b0; cyc = 2;
    n_tests++;
    if (out_rden !== 1'b1 || out_rd_address !== 8'd0 || out_rd_cell !== 12'h111 ||
        motion_update_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL sweep_begin: rden %b addr %0d cell %h en %b want 1 0 111 1",
               out_rden, out_rd_address, out_rd_cell, motion_update_enable);
    end
    while (!out_done && cyc < 20000) begin
      start = (cyc == extra_at);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    n_tests++;
    if (!out_done) begin
      n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles, want done", cyc);
    end else if (motion_update_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_at_done: got %b want 0", motion_update_enable);
    end
    @(negedge clk); #1;
  endtask

  task automatic finish_checks(input int cyc, input int exp_cyc, input int exp_beats);
    repeat (4) @(posedge clk);
    #1;
    n_tests++;
    if (cyc != exp_cyc) begin
      n_fail++; $display("FAIL sweep_cycles: got %0d want %0d", cyc, exp_cyc);
    end
    n_tests++;
    if (beats != exp_beats || reads != exp_beats) begin
      n_fail++; $display("FAIL beat_count: got %0d beats %0d reads want %0d", beats, reads, exp_beats);
    end
    n_tests++;
    if (done_cnt != 1) begin
      n_fail++; $display("FAIL done_pulses: got %0d want 1", done_cnt);
    end
    n_tests++;
    if (q_data.size() != 0 || motion_update_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL sweep_end: pending %0d enable %b want 0 0", q_data.size(), motion_update_enable);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    clear_sb();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({out_rden, out_rd_address, out_rd_cell, motion_update_enable, out_data,
         out_data_dst_cell, out_data_valid, out_done} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got nonzero want all 0");
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int c;
    mode = 0; set_counts(0); cnts[0] = 3; clear_sb();
    run_sweep(0, c);
    finish_checks(c, sweep_len(), 3);
    n_tests++;
    if (last_beat !== {32'd29, 32'd22, 32'd11}) begin
      n_fail++; $display("FAIL single_value: got %h want %h", last_beat, {32'd29, 32'd22, 32'd11});
    end
  endtask

  task automatic test_empty();
    int c;
    mode = 1; set_counts(0); clear_sb();
    run_sweep(0, c);
    finish_checks(c, NCELL * (2 + RL) + 2, 0);
  endtask

  task automatic test_clamp();
    int c;
    mode = 1; set_counts(0); cnts[cidx(12'h231)] = 250; clear_sb();
    run_sweep(0, c);
    finish_checks(c, sweep_len(), 220);
  endtask

  task automatic test_wrap();
    int c;
    mode = 2; set_counts(0); cnts[NCELL-1] = 1; clear_sb();
    run_sweep(0, c);
    finish_checks(c, sweep_len(), 1);
    n_tests++;
    if (last_beat !== {32'd0, 32'd0, 32'h80000000}) begin
      n_fail++; $display("FAIL wrap_value: got %h want %h", last_beat, {32'd0, 32'd0, 32'h80000000});
    end
  endtask

  task automatic test_random();
    int c;
    mode = 1; set_counts(1); clear_sb();
    run_sweep(0, c);
    finish_checks(c, sweep_len(), total_beats());
  endtask

  task automatic test_reset_mid();
    int c, k;
    mode = 1; set_counts(0); cnts[0] = 50; clear_sb(); done_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 0;
    while (out_rd_address != 8'd10 && k < 200) begin @(posedge clk); #1; k++; end
    n_tests++;
    if (out_rd_address != 8'd10) begin
      n_fail++; $display("FAIL stream_timeout: got addr %0d want 10", out_rd_address);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({out_rden, out_rd_address, out_rd_cell, motion_update_enable, out_data,
         out_data_dst_cell, out_data_valid, out_done} !== '0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got nonzero want all 0");
    end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_sb();
    n_tests++;
    if (done_cnt != 0) begin
      n_fail++; $display("FAIL abort_done: got %0d want 0", done_cnt);
    end
    run_sweep(0, c);
    finish_checks(c, sweep_len(), 50);
  endtask

  task automatic test_start_ignored();
    int c;
    mode = 1; set_counts(1); clear_sb();
    run_sweep(20, c);
    finish_checks(c, sweep_len(), total_beats());
  endtask

  task automatic test_back_to_back();
    int c1, c2, b1, d1;
    mode = 1; set_counts(1); clear_sb();
    run_sweep(0, c1);
    b1 = beats; d1 = done_cnt;
    run_sweep(0, c2);
    n_tests++;
    if (c1 != sweep_len() || b1 != total_beats() || d1 != 1) begin
      n_fail++;
      $display("FAIL first_of_pair: got %0d cyc %0d beats %0d done want %0d %0d 1",
               c1, b1, d1, sweep_len(), total_beats());
    end
    finish_checks(c2, sweep_len(), total_beats());
  endtask

  initial begin
    test_reset();
    test_single();
    test_empty();
    test_clamp();
    test_wrap();
    test_random();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
